// File: rtl/multi_score_engine_if.sv
// Game-logic <-> score engine bundle: per-channel run controls in, scores and high-score status out.
// master = game logic / display side, slave = multi_score_engine.
interface multi_score_engine_if #(
    parameter int NUM_CH  = 2,
    parameter int SCORE_W = 32,
    parameter int DIFF_W  = 2
);
    localparam int HCH_W = $clog2(NUM_CH) + 1;

    logic [NUM_CH-1:0]         start;
    logic [NUM_CH-1:0]         score_in;
    logic [NUM_CH-1:0]         crash;
    logic [DIFF_W-1:0]         difficulty;
    logic [NUM_CH*SCORE_W-1:0] score;
    logic [NUM_CH-1:0]         running;
    logic [NUM_CH-1:0]         sat;
    logic [SCORE_W-1:0]        high_score;
    logic [HCH_W-1:0]          high_ch;
    logic                      new_high;

    modport master (
        output start, score_in, crash, difficulty,
        input  score, running, sat, high_score, high_ch, new_high
    );

    modport slave (
        input  start, score_in, crash, difficulty,
        output score, running, sat, high_score, high_ch, new_high
    );
endinterface

// File: rtl/multi_score_engine.sv
// Multi-channel score engine: per-channel saturating score accumulators
// driven by frame-rate clears, plus a session high score across runs.
// Optional combo bonus: define SCORE_COMBO_EN to add min(streak, COMBO_MAX)
// to each clear after the first of a consecutive streak.
//
// state | meaning
// IDLE  | channel not started, score held at 0
// RUN   | accumulating clears, watching for crash or abort
// DONE  | crashed, final score held until start drops
module multi_score_engine #(
    parameter int NUM_CH    = 2,
    parameter int SCORE_W   = 32,
    parameter int DIFF_W    = 2,
    parameter int COMBO_MAX = 3
) (
    input  logic                clock_div,
    input  logic                reset,
    multi_score_engine_if.slave bus
);
    localparam int HCH_W = $clog2(NUM_CH) + 1;
    localparam int CMB_W = $clog2(COMBO_MAX + 2);
    localparam int PTS_W = ((DIFF_W > CMB_W) ? DIFF_W : CMB_W) + 1;
    localparam int SUM_W = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    ch_state_t           state_q [NUM_CH];
    logic [SCORE_W-1:0]  score_q [NUM_CH];
    logic [NUM_CH-1:0]   running_q;
    logic [NUM_CH-1:0]   sat_q;
    logic [SCORE_W-1:0]  high_score_q;
    logic [HCH_W-1:0]    high_ch_q;
    logic                new_high_q;
`ifdef SCORE_COMBO_EN
    // Streak saturates at COMBO_MAX, which is all the bonus ever needs.
    logic [CMB_W-1:0]    streak_q [NUM_CH];
`endif

    logic [PTS_W-1:0]          pts_w [NUM_CH];
    logic [SUM_W-1:0]          sum_w [NUM_CH];
    logic [NUM_CH-1:0]         ovf_w;
    logic                      crash_any_w;
    logic [SCORE_W-1:0]        crash_best_w;
    logic [HCH_W-1:0]          crash_ch_w;
    logic [NUM_CH*SCORE_W-1:0] score_flat_w;

    // Points for a clear this cycle and the widened sum used to detect saturation.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef SCORE_COMBO_EN
            pts_w[i] = PTS_W'(bus.difficulty) + PTS_W'(streak_q[i]);
`else
            pts_w[i] = PTS_W'(bus.difficulty);
`endif
            sum_w[i] = SUM_W'(score_q[i]) + SUM_W'(pts_w[i]);
            ovf_w[i] = (sum_w[i] > SUM_W'(SCORE_MAX));
        end
    end

    // Best frozen score among channels crashing this cycle; ascending scan with strict compare keeps the lowest index on ties.
    always_comb begin
        crash_any_w  = 1'b0;
        crash_best_w = '0;
        crash_ch_w   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state_q[i] == ST_RUN) && bus.start[i] && bus.crash[i] &&
                (!crash_any_w || (score_q[i] > crash_best_w))) begin
                crash_any_w  = 1'b1;
                crash_best_w = score_q[i];
                crash_ch_w   = HCH_W'(i);
            end
        end
    end

    // Channel FSMs, accumulators and the session high score.
    always_ff @(posedge clock_div) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                score_q[i] <= '0;
`ifdef SCORE_COMBO_EN
                streak_q[i] <= '0;
`endif
            end
            running_q    <= '0;
            sat_q        <= '0;
            high_score_q <= '0;
            high_ch_q    <= '0;
            new_high_q   <= 1'b0;
        end else begin
            new_high_q <= 1'b0;
            if (crash_any_w && (crash_best_w > high_score_q)) begin
                high_score_q <= crash_best_w;
                high_ch_q    <= crash_ch_w;
                new_high_q   <= 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        score_q[i] <= '0;
                        if (bus.start[i]) begin
                            state_q[i]   <= ST_RUN;
                            running_q[i] <= 1'b1;
                            sat_q[i]     <= 1'b0;
`ifdef SCORE_COMBO_EN
                            streak_q[i]  <= '0;
`endif
                        end
                    end
                    ST_RUN: begin
                        if (!bus.start[i]) begin
                            state_q[i]   <= ST_IDLE;
                            running_q[i] <= 1'b0;
                            score_q[i]   <= '0;
                        end else if (bus.crash[i]) begin
                            state_q[i]   <= ST_DONE;
                            running_q[i] <= 1'b0;
                        end else if (bus.score_in[i]) begin
                            if (ovf_w[i]) begin
                                score_q[i] <= SCORE_MAX;
                                sat_q[i]   <= 1'b1;
                            end else begin
                                score_q[i] <= sum_w[i][SCORE_W-1:0];
                            end
`ifdef SCORE_COMBO_EN
                            if (streak_q[i] < CMB_W'(COMBO_MAX)) begin
                                streak_q[i] <= streak_q[i] + CMB_W'(1);
                            end
                        end else begin
                            streak_q[i] <= '0;
`endif
                        end
                    end
                    ST_DONE: begin
                        if (!bus.start[i]) begin
                            state_q[i] <= ST_IDLE;
                            score_q[i] <= '0;
                        end
                    end
                    default: begin
                        state_q[i]   <= ST_IDLE;
                        running_q[i] <= 1'b0;
                        score_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Pack channel scores onto the flat output bus.
    always_comb begin
        score_flat_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            score_flat_w[i*SCORE_W +: SCORE_W] = score_q[i];
        end
    end

    assign bus.score      = score_flat_w;
    assign bus.running    = running_q;
    assign bus.sat        = sat_q;
    assign bus.high_score = high_score_q;
    assign bus.high_ch    = high_ch_q;
    assign bus.new_high   = new_high_q;
endmodule

// File: tb/tb_multi_score_engine.sv
// Self-checking bench for multi_score_engine: directed scenarios plus a
// randomized run against a behavioural model of the scoring rules.
module tb_multi_score_engine;
    localparam int NUM_CH    = 3;
    localparam int SCORE_W   = 4;
    localparam int DIFF_W    = 2;
    localparam int COMBO_MAX = 3;
    localparam int HCH_W     = $clog2(NUM_CH) + 1;
    localparam int SMAX      = (1 << SCORE_W) - 1;

    logic clock_div = 1'b0;
    logic reset     = 1'b1;

    multi_score_engine_if #(.NUM_CH(NUM_CH), .SCORE_W(SCORE_W), .DIFF_W(DIFF_W)) bus ();

    multi_score_engine #(
        .NUM_CH(NUM_CH), .SCORE_W(SCORE_W), .DIFF_W(DIFF_W), .COMBO_MAX(COMBO_MAX)
    ) dut (
        .clock_div(clock_div),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock_div = ~clock_div;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = finished
    int m_st     [NUM_CH];
    int m_score  [NUM_CH];
    int m_streak [NUM_CH];
    bit m_sat    [NUM_CH];
    int m_high;
    int m_hch;
    bit m_new;

    task automatic model_step();
        int best;
        int best_ch;
        int pts;
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_st[i] = 0; m_score[i] = 0; m_streak[i] = 0; m_sat[i] = 0;
            end
            m_high = 0; m_hch = 0; m_new = 0;
            return;
        end
        best = -1;
        best_ch = 0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_st[i] == 1 && bus.start[i] && bus.crash[i] && m_score[i] > best) best = m_score[i];
        if (best >= 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (m_st[i] == 1 && bus.start[i] && bus.crash[i] && m_score[i] == best) best_ch = i;
        end
        m_new = 0;
        if (best > m_high) begin
            m_high = best; m_hch = best_ch; m_new = 1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_st[i] == 0) begin
                if (bus.start[i]) begin
                    m_st[i] = 1; m_score[i] = 0; m_sat[i] = 0; m_streak[i] = 0;
                end
            end else if (m_st[i] == 1) begin
                if (!bus.start[i]) begin
                    m_st[i] = 0; m_score[i] = 0;
                end else if (bus.crash[i]) begin
                    m_st[i] = 2;
                end else if (bus.score_in[i]) begin
                    pts = int'(bus.difficulty);
`ifdef SCORE_COMBO_EN
                    pts += (m_streak[i] < COMBO_MAX) ? m_streak[i] : COMBO_MAX;
`endif
                    if (m_score[i] + pts > SMAX) begin
                        m_score[i] = SMAX; m_sat[i] = 1;
                    end else begin
                        m_score[i] += pts;
                    end
                    m_streak[i]++;
                end else begin
                    m_streak[i] = 0;
                end
            end else begin
                if (!bus.start[i]) begin
                    m_st[i] = 0; m_score[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock_div);
        model_step();
        #1;
    endtask

    function automatic int ch_score(int i);
        logic [SCORE_W-1:0] s;
        s = bus.score[i*SCORE_W +: SCORE_W];
        return int'(s);
    endfunction

    task automatic do_reset();
        bus.start = '0; bus.score_in = '0; bus.crash = '0; bus.difficulty = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = '1; bus.score_in = '1; bus.crash = '0; bus.difficulty = 2'd3;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.score !== '0 || bus.running !== '0 || bus.sat !== '0) begin
            n_bad++;
            $display("FAIL reset_channels: score=%h running=%b sat=%b, required all 0", bus.score, bus.running, bus.sat);
        end
        n_cmp++;
        if (bus.high_score !== '0 || bus.high_ch !== '0 || bus.new_high !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_high: high=%0d ch=%0d new=%b, required 0/0/0", bus.high_score, bus.high_ch, bus.new_high);
        end
        reset = 1'b0;
        bus.start = '0; bus.score_in = '0;
    endtask

    task automatic test_single_clear();
        do_reset();
        bus.start = 3'b001; bus.difficulty = 2'd1;
        tick();
        n_cmp++;
        if (bus.running !== 3'b001 || ch_score(0) !== 0) begin
            n_bad++;
            $display("FAIL start_run: running=%b score0=%0d, required 001/0", bus.running, ch_score(0));
        end
        bus.score_in = 3'b001;
        tick();
        bus.score_in = '0;
        n_cmp++;
        if (ch_score(0) !== 1 || bus.running[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_clear: score0=%0d running0=%b, required 1/1", ch_score(0), bus.running[0]);
        end
    endtask

    task automatic test_difficulty();
        int req;
`ifdef SCORE_COMBO_EN
        req = 10;
`else
        req = 7;
`endif
        do_reset();
        bus.start = 3'b001;
        tick();
        bus.difficulty = 2'd1; bus.score_in = 3'b001;
        tick();
        bus.difficulty = 2'd3;
        tick();
        tick();
        bus.score_in = '0;
        n_cmp++;
        if (ch_score(0) !== req) begin
            n_bad++;
            $display("FAIL difficulty_change: score0=%0d, required %0d", ch_score(0), req);
        end
    endtask

    task automatic test_crash_high();
        do_reset();
        bus.start = 3'b011; bus.difficulty = 2'd2;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.score_in = 3'b001; tick();
            bus.score_in = 3'b000; tick();
        end
        bus.crash = 3'b001; bus.score_in = 3'b001;
        tick();
        bus.crash = '0; bus.score_in = '0;
        n_cmp++;
        if (ch_score(0) !== 10 || bus.running[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL crash_freeze: score0=%0d running0=%b, required 10/0", ch_score(0), bus.running[0]);
        end
        n_cmp++;
        if (bus.high_score !== 4'd10 || bus.high_ch !== '0 || bus.new_high !== 1'b1) begin
            n_bad++;
            $display("FAIL first_high: high=%0d ch=%0d new=%b, required 10/0/1", bus.high_score, bus.high_ch, bus.new_high);
        end
        tick();
        n_cmp++;
        if (bus.new_high !== 1'b0 || ch_score(0) !== 10 || bus.running[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL done_hold: new=%b score0=%0d running0=%b, required 0/10/0", bus.new_high, ch_score(0), bus.running[0]);
        end
        for (int k = 0; k < 5; k++) begin
            bus.score_in = 3'b010; tick();
            bus.score_in = 3'b000; tick();
        end
        bus.crash = 3'b010;
        tick();
        bus.crash = '0;
        n_cmp++;
        if (bus.high_score !== 4'd10 || bus.high_ch !== '0 || bus.new_high !== 1'b0 || ch_score(1) !== 10) begin
            n_bad++;
            $display("FAIL tie_keeps_holder: high=%0d ch=%0d new=%b score1=%0d, required 10/0/0/10",
                     bus.high_score, bus.high_ch, bus.new_high, ch_score(1));
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        do_reset();
        bus.start = 3'b111;
        tick();
        bus.difficulty = 2'd3; bus.score_in = 3'b110; tick();
        bus.score_in = 3'b000; tick();
        bus.difficulty = 2'd3; bus.score_in = 3'b111; tick();
        bus.score_in = 3'b000; tick();
        bus.difficulty = 2'd3; bus.score_in = 3'b110; tick();
        bus.score_in = 3'b000; tick();
        bus.difficulty = 2'd2; bus.score_in = 3'b001; tick();
        bus.score_in = 3'b000;
        n_cmp++;
        if (ch_score(0) !== 5 || ch_score(1) !== 9 || ch_score(2) !== 9) begin
            n_bad++;
            $display("FAIL sim_setup: scores=%0d/%0d/%0d, required 5/9/9", ch_score(0), ch_score(1), ch_score(2));
        end
        bus.crash = 3'b111;
        tick();
        bus.crash = '0;
        pulses = int'(bus.new_high);
        n_cmp++;
        if (bus.high_score !== 4'd9 || bus.high_ch !== HCH_W'(1)) begin
            n_bad++;
            $display("FAIL sim_crash_winner: high=%0d ch=%0d, required 9/1", bus.high_score, bus.high_ch);
        end
        tick();
        pulses += int'(bus.new_high);
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL sim_single_pulse: pulses=%0d, required 1", pulses);
        end
    endtask

    task automatic test_saturation();
        int req [6];
`ifdef SCORE_COMBO_EN
        req = '{3, 7, 12, 15, 15, 15};
`else
        req = '{3, 6, 9, 12, 15, 15};
`endif
        do_reset();
        bus.start = 3'b001;
        tick();
        bus.difficulty = 2'd3; bus.score_in = 3'b001;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (ch_score(0) !== req[k] || bus.sat[0] !== (req[k] + 3 > SMAX && k > 0 && req[k-1] + 3 > SMAX ? 1'b1 : bus.sat[0])) begin
                n_bad++;
                $display("FAIL sat_step%0d: score0=%0d, required %0d", k, ch_score(0), req[k]);
            end
        end
        bus.score_in = '0;
        n_cmp++;
        if (bus.sat[0] !== 1'b1 || bus.sat[2:1] !== 2'b00) begin
            n_bad++;
            $display("FAIL sat_flag: sat=%b, required 001", bus.sat);
        end
    endtask

    task automatic test_abort_reset();
        do_reset();
        bus.start = 3'b011; bus.difficulty = 2'd2;
        tick();
        bus.score_in = 3'b011; tick();
        bus.score_in = 3'b000;
        bus.start = 3'b010; bus.crash = 3'b001;
        tick();
        bus.crash = '0;
        n_cmp++;
        if (ch_score(0) !== 0 || bus.running[0] !== 1'b0 || bus.high_score !== '0 || bus.new_high !== 1'b0) begin
            n_bad++;
            $display("FAIL abort: score0=%0d running0=%b high=%0d new=%b, required 0/0/0/0",
                     ch_score(0), bus.running[0], bus.high_score, bus.new_high);
        end
        bus.crash = 3'b010; tick();
        bus.crash = '0;
        bus.start = 3'b011; bus.score_in = 3'b001; tick(); tick();
        reset = 1'b1; bus.crash = 3'b001;
        tick();
        reset = 1'b0; bus.crash = '0;
        n_cmp++;
        if (bus.score !== '0 || bus.running !== '0 || bus.sat !== '0 ||
            bus.high_score !== '0 || bus.high_ch !== '0 || bus.new_high !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_run_reset: score=%h running=%b high=%0d new=%b, required all 0",
                     bus.score, bus.running, bus.high_score, bus.new_high);
        end
        bus.start = '0; bus.score_in = '0;
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] exp_run;
        logic [NUM_CH-1:0] exp_sat;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(7) == 0) bus.start[i] = ~bus.start[i];
                bus.crash[i] = ($urandom_range(5) == 0);
            end
            bus.score_in   = NUM_CH'($urandom);
            bus.difficulty = DIFF_W'($urandom);
            reset          = ($urandom_range(79) == 0);
            tick();
            for (int i = 0; i < NUM_CH; i++) begin
                exp_run[i] = (m_st[i] == 1);
                exp_sat[i] = m_sat[i];
                n_cmp++;
                if (ch_score(i) !== m_score[i]) begin
                    n_bad++;
                    $display("FAIL rand_score%0d cyc%0d: got %0d, required %0d", i, c, ch_score(i), m_score[i]);
                end
            end
            n_cmp++;
            if (bus.running !== exp_run || bus.sat !== exp_sat) begin
                n_bad++;
                $display("FAIL rand_flags cyc%0d: running=%b sat=%b, required %b/%b", c, bus.running, bus.sat, exp_run, exp_sat);
            end
            n_cmp++;
            if (bus.high_score !== SCORE_W'(m_high) || bus.high_ch !== HCH_W'(m_hch) || bus.new_high !== m_new) begin
                n_bad++;
                $display("FAIL rand_high cyc%0d: high=%0d ch=%0d new=%b, required %0d/%0d/%b",
                         c, bus.high_score, bus.high_ch, bus.new_high, m_high, m_hch, m_new);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.start = '0; bus.score_in = '0; bus.crash = '0; bus.difficulty = '0;
        test_reset();
        test_single_clear();
        test_difficulty();
        test_crash_high();
        test_simultaneous();
        test_saturation();
        test_abort_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
